// File: rtl/fixed_point_iterative_divider.sv
// Iterative signed fixed-point divider, c = a / b, on Q(n-d).d two's-complement words.
// Restoring division on magnitudes, one quotient bit per cycle, behind a val/rdy handshake.
module fixed_point_iterative_divider #(
    parameter int n = 32,
    parameter int d = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] c
);

    localparam int W  = n + d;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Magnitude as unsigned n bits; the most-negative word maps onto 2^(n-1).
    function automatic logic [n-1:0] f_abs(input logic [n-1:0] x);
        logic [n-1:0] res;
        if (x[n-1]) begin
            res = ~x + {{(n-1){1'b0}}, 1'b1};
        end else begin
            res = x;
        end
        return res;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dvd;
    logic [n:0]    r_rem;
    logic [n-1:0]  r_divs;
    logic          r_sign;
    logic          r_dz;
    logic          r_a_neg;
    logic [n-1:0]  r_c;
    logic          r_recv_rdy;
    logic          r_send_val;

    logic [n:0]    w_rem_shift;
    logic [n:0]    w_rem_sub;
    logic          w_q_bit;
    logic [n-1:0]  w_q_mag;
    logic [n-1:0]  w_c_nxt;

    assign recv_rdy = r_recv_rdy;
    assign send_val = r_send_val;
    assign c        = r_c;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the counter hitting zero marks the finalisation cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (recv_val) begin
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE: begin
                if (send_rdy) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        w_rem_shift = {r_rem[n-1:0], r_dvd[W-1]};
        w_q_bit     = (w_rem_shift >= {1'b0, r_divs});
        if (w_q_bit) begin
            w_rem_sub = w_rem_shift - {1'b0, r_divs};
        end else begin
            w_rem_sub = w_rem_shift;
        end
    end

    // Result formatting: low n quotient bits, signed; divide-by-zero saturates on a's sign.
    always_comb begin
        w_q_mag = r_dvd[n-1:0];
        w_c_nxt = {n{1'b0}};
        if (r_dz) begin
            if (r_a_neg) begin
                w_c_nxt = {1'b1, {(n-1){1'b0}}};
            end else begin
                w_c_nxt = {1'b0, {(n-1){1'b1}}};
            end
        end else if (r_sign) begin
            w_c_nxt = ~w_q_mag + {{(n-1){1'b0}}, 1'b1};
        end else begin
            w_c_nxt = w_q_mag;
        end
    end

    // Datapath and registered handshake outputs. Dividend bits leave at the top of
    // r_dvd while quotient bits enter at the bottom, so r_dvd ends up holding Q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= {CW{1'b0}};
            r_dvd      <= {W{1'b0}};
            r_rem      <= {(n+1){1'b0}};
            r_divs     <= {n{1'b0}};
            r_sign     <= 1'b0;
            r_dz       <= 1'b0;
            r_a_neg    <= 1'b0;
            r_c        <= {n{1'b0}};
            r_recv_rdy <= 1'b1;
            r_send_val <= 1'b0;
        end else begin
            r_recv_rdy <= (w_state_nxt == S_IDLE);
            r_send_val <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (recv_val) begin
                        r_dvd   <= W'(f_abs(a)) << d;
                        r_rem   <= {(n+1){1'b0}};
                        r_divs  <= f_abs(b);
                        r_sign  <= a[n-1] ^ b[n-1];
                        r_dz    <= (b == {n{1'b0}});
                        r_a_neg <= a[n-1];
                        r_cnt   <= CW'(W);
                    end
                end
                S_CALC: begin
                    if (r_cnt != {CW{1'b0}}) begin
                        r_rem <= w_rem_sub;
                        r_dvd <= {r_dvd[W-2:0], w_q_bit};
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        r_c <= w_c_nxt;
                    end
                end
                S_DONE: begin
                    r_c <= r_c;
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_iterative_divider.sv
// Self-checking bench: directed vector table, handshake/reset corner sequences and
// randomized operands checked against an arithmetic reference model.
module tb_fixed_point_iterative_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] a;
    logic [31:0] b;
    logic        send_val;
    logic        send_rdy;
    logic [31:0] c;

    int checks   = 0;
    int failures = 0;

    fixed_point_iterative_divider #(.n(32), .d(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .a        (a),
        .b        (b),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .c        (c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vexp;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division of (a * 2^16) by b, keep low 32 bits.
    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned q;
        logic [31:0]     mag;
        if (mb == 32'd0) begin
            return ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        ua  = ma[31] ? (64'd4294967296 - {32'd0, ma}) : {32'd0, ma};
        ub  = mb[31] ? (64'd4294967296 - {32'd0, mb}) : {32'd0, mb};
        q   = (ua << 16) / ub;
        mag = q[31:0];
        return (ma[31] ^ mb[31]) ? (~mag + 32'd1) : mag;
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input int hold,
                          output logic [31:0] rc, output int lat);
        int k;
        k = 0;
        while (!recv_rdy && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("recv_rdy_before_op", {31'd0, recv_rdy}, 32'd1);
        a = ta; b = tb_; recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        while (!send_val && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        rc = c;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_send_val", {31'd0, send_val}, 32'd1);
            check("hold_c", c, rc);
            check("hold_recv_rdy", {31'd0, recv_rdy}, 32'd0);
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
        check("after_send_recv_rdy", {31'd0, recv_rdy}, 32'd1);
        check("after_send_send_val", {31'd0, send_val}, 32'd0);
    endtask

    initial begin
        vec_t        vecs[7];
        logic [31:0] rc;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;

        vecs[0] = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 10};
        vecs[1] = '{32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 0};
        vecs[2] = '{32'h0001_0000, 32'hFFFD_0000, 32'hFFFF_AAAB, 0};
        vecs[3] = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 0};
        vecs[4] = '{32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 0};
        vecs[5] = '{32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[6] = '{32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000, 0};

        reset = 1'b0; recv_val = 1'b0; send_rdy = 1'b0; a = 32'd0; b = 32'd0;
        #12;
        check("reset_send_val", {31'd0, send_val}, 32'd0);
        check("reset_c", c, 32'd0);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_recv_rdy", {31'd0, recv_rdy}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].hold, rc, lat);
            check($sformatf("vec%0d_c", i), rc, vecs[i].vexp);
            check($sformatf("vec%0d_latency", i), lat, 32'd49);
        end

        // Asynchronous reset in the middle of an operation.
        a = 32'h0005_0000; b = 32'h0002_0000; recv_val = 1'b1;
        @(posedge clk); #1;
        recv_val = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_send_val", {31'd0, send_val}, 32'd0);
        check("midreset_c", c, 32'd0);
        #4 reset = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            check("postabort_send_val", {31'd0, send_val}, 32'd0);
            check("postabort_recv_rdy", {31'd0, recv_rdy}, 32'd1);
        end
        run_op(32'h0006_0000, 32'h0002_0000, 0, rc, lat);
        check("fresh_op_c", rc, 32'h0003_0000);
        check("fresh_op_latency", lat, 32'd49);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = {($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000, 16'($urandom_range(1, 65535))};
                2: rb = 32'd0;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (i % 7 == 3) ra = 32'h8000_0000;
            run_op(ra, rb, 0, rc, lat);
            check($sformatf("rand%0d_c a=%08h b=%08h", i, ra, rb), rc, model(ra, rb));
            check($sformatf("rand%0d_latency", i), lat, 32'd49);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
